// File: rtl/lockstep_cmp.sv
// Lockstep self-check comparator: per-vector verdict, saturating statistics and sticky error.
// Optional first-mismatch capture is built when LOCKSTEP_CMP_FIRST_CAPTURE_EN is defined.
//
//   state   | meaning
//   --------+---------------------------------------------
//   IDLE    | no vector accepted since reset/clear
//   PASSING | at least one vector accepted, all matched
//   FAILED  | a mismatch was seen; held until reset/clear
module lockstep_cmp #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] dut_f,
    input  logic [WIDTH-1:0] ref_f,
    output logic             valid_out,
    output logic             pass,
    output logic             fail,
    output logic [WIDTH-1:0] diff,
    output logic             err_sticky,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_idx,
    output logic [WIDTH-1:0] first_diff
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PASSING = 2'd1,
        FAILED  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] cur_diff;
    logic             mis;
    logic             accept;

    assign cur_diff   = dut_f ^ ref_f;
    assign mis        = |cur_diff;
    // clear wins over a same-cycle vector, which is dropped entirely
    assign accept     = valid_in && !clear;
    assign err_sticky = (state == FAILED);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = mis ? FAILED : PASSING;
                end
            end
            PASSING: begin
                if (accept && mis) begin
                    state_nxt = FAILED;
                end
            end
            FAILED:  state_nxt = FAILED;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid_out <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            diff      <= '0;
            vec_cnt   <= '0;
            err_cnt   <= '0;
        end else begin
            valid_out <= valid_in;
            pass      <= valid_in && !mis;
            fail      <= valid_in && mis;
            diff      <= valid_in ? cur_diff : '0;
            if (valid_in && (vec_cnt != CNT_MAX)) begin
                vec_cnt <= vec_cnt + 1'b1;
            end
            if (valid_in && mis && (err_cnt != CNT_MAX)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

`ifdef LOCKSTEP_CMP_FIRST_CAPTURE_EN
    logic capture;

    // first_idx records the zero-based index, i.e. vec_cnt before it increments
    assign capture = accept && mis && (state != FAILED);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            first_idx  <= '0;
            first_diff <= '0;
        end else if (capture) begin
            first_idx  <= vec_cnt;
            first_diff <= cur_diff;
        end
    end
`else
    assign first_idx  = '0;
    assign first_diff = '0;
`endif

endmodule

// File: tb/tb_lockstep_cmp.sv
// Scoreboard bench for lockstep_cmp: a WIDTH=8 main instance, a CNT_W=2 instance fed
// the same vectors for saturation, and a WIDTH=1 instance for the exhaustive XOR pair.
module tb_lockstep_cmp;

`ifdef LOCKSTEP_CMP_FIRST_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;

    logic        m_valid = 1'b0;
    logic [7:0]  m_dut = '0, m_ref = '0;
    logic        m_valid_out, m_pass, m_fail, m_err_sticky;
    logic [7:0]  m_diff, m_first_diff;
    logic [15:0] m_vec_cnt, m_err_cnt, m_first_idx;

    logic        s_valid_out, s_pass, s_fail, s_err_sticky;
    logic [7:0]  s_diff, s_first_diff;
    logic [1:0]  s_vec_cnt, s_err_cnt, s_first_idx;

    logic        x_valid = 1'b0;
    logic        x_dut = 1'b0, x_ref = 1'b0;
    logic        x_valid_out, x_pass, x_fail, x_err_sticky, x_diff, x_first_diff;
    logic [15:0] x_vec_cnt, x_err_cnt, x_first_idx;

    int n_vec = 0;
    int n_mis = 0;

    logic [9:0] exp_q[$];
    logic [2:0] xq[$];

    logic        mdl_sticky;
    logic [15:0] mdl_vec, mdl_err, mdl_fidx;
    logic [7:0]  mdl_fdiff;

    always #5 clk = ~clk;

    lockstep_cmp #(.WIDTH(8), .CNT_W(16)) u_main (
        .clk(clk), .rst(rst), .clear(clear), .valid_in(m_valid),
        .dut_f(m_dut), .ref_f(m_ref),
        .valid_out(m_valid_out), .pass(m_pass), .fail(m_fail), .diff(m_diff),
        .err_sticky(m_err_sticky), .vec_cnt(m_vec_cnt), .err_cnt(m_err_cnt),
        .first_idx(m_first_idx), .first_diff(m_first_diff)
    );

    lockstep_cmp #(.WIDTH(8), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .clear(clear), .valid_in(m_valid),
        .dut_f(m_dut), .ref_f(m_ref),
        .valid_out(s_valid_out), .pass(s_pass), .fail(s_fail), .diff(s_diff),
        .err_sticky(s_err_sticky), .vec_cnt(s_vec_cnt), .err_cnt(s_err_cnt),
        .first_idx(s_first_idx), .first_diff(s_first_diff)
    );

    lockstep_cmp #(.WIDTH(1), .CNT_W(16)) u_xor (
        .clk(clk), .rst(rst), .clear(clear), .valid_in(x_valid),
        .dut_f(x_dut), .ref_f(x_ref),
        .valid_out(x_valid_out), .pass(x_pass), .fail(x_fail), .diff(x_diff),
        .err_sticky(x_err_sticky), .vec_cnt(x_vec_cnt), .err_cnt(x_err_cnt),
        .first_idx(x_first_idx), .first_diff(x_first_diff)
    );

    task automatic model_reset();
        mdl_sticky = 1'b0;
        mdl_vec    = '0;
        mdl_err    = '0;
        mdl_fidx   = '0;
        mdl_fdiff  = '0;
        exp_q.delete();
        xq.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; clear = 1'b0; m_valid = 1'b0; x_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    // Drives one vector into the main/saturation instances and records the expected result.
    task automatic drive(input logic [7:0] d, input logic [7:0] r);
        logic [7:0] x;
        x = d ^ r;
        @(negedge clk);
        m_valid = 1'b1; m_dut = d; m_ref = r;
        exp_q.push_back({(x == 8'h00), (x != 8'h00), x});
        if (x != 8'h00 && !mdl_sticky) begin
            mdl_sticky = 1'b1;
            mdl_fidx   = mdl_vec;
            mdl_fdiff  = x;
        end
        if (x != 8'h00) mdl_err = mdl_err + 1'b1;
        mdl_vec = mdl_vec + 1'b1;
        @(posedge clk);
        #1 m_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({m_valid_out, m_pass, m_fail, m_diff, m_err_sticky, m_vec_cnt, m_err_cnt,
             m_first_idx, m_first_diff} !== '0) begin
            n_mis++;
            $display("FAIL reset_main: vec=%0d err=%0d sticky=%b vo=%b, required all 0",
                     m_vec_cnt, m_err_cnt, m_err_sticky, m_valid_out);
        end
        n_vec++;
        if ({s_valid_out, s_pass, s_fail, s_diff, s_err_sticky, s_vec_cnt, s_err_cnt,
             s_first_idx, s_first_diff, x_valid_out, x_pass, x_fail, x_diff, x_err_sticky,
             x_vec_cnt, x_err_cnt, x_first_idx, x_first_diff} !== '0) begin
            n_mis++;
            $display("FAIL reset_aux: s_vec=%0d x_vec=%0d, required all 0", s_vec_cnt, x_vec_cnt);
        end
    endtask

    task automatic test_xor_exhaustive();
        logic a, b;
        logic [2:0] e;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a = i[0]; b = i[1];
            @(negedge clk);
            x_valid = 1'b1;
            x_dut = a ^ b;
            x_ref = (a | b) & ~(a & b);
            xq.push_back(3'b100);
            @(posedge clk);
            #1 x_valid = 1'b0;
            n_vec++;
            e = (xq.size() > 0) ? xq.pop_front() : 3'b000;
            if (!x_valid_out || {x_pass, x_fail, x_diff} !== e) begin
                n_mis++;
                $display("FAIL xor_verdict[%0d]: vo=%b pf_diff=%b, required vo=1 %b",
                         i, x_valid_out, {x_pass, x_fail, x_diff}, e);
            end
        end
        n_vec++;
        if (x_vec_cnt !== 16'd4 || x_err_cnt !== 16'd0 || x_err_sticky !== 1'b0) begin
            n_mis++;
            $display("FAIL xor_stats: vec=%0d err=%0d sticky=%b, required 4 0 0",
                     x_vec_cnt, x_err_cnt, x_err_sticky);
        end
    endtask

    task automatic test_injected_fault();
        logic [7:0] d, r;
        logic [9:0] e;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            d = (i == 3) ? 8'hA5 : (i == 4) ? 8'h80 : 8'h30 + 8'(i);
            r = (i == 3) ? 8'hA4 : (i == 4) ? 8'h00 : d;
            drive(d, r);
            n_vec++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
            if (!m_valid_out || {m_pass, m_fail, m_diff} !== e) begin
                n_mis++;
                $display("FAIL fault_verdict[%0d]: vo=%b pf_diff=%h, required vo=1 %h",
                         i, m_valid_out, {m_pass, m_fail, m_diff}, e);
            end
            n_vec++;
            if ({m_err_sticky, m_vec_cnt, m_err_cnt, m_first_idx, m_first_diff} !==
                {mdl_sticky, mdl_vec, mdl_err, CAP ? mdl_fidx : 16'd0, CAP ? mdl_fdiff : 8'd0}) begin
                n_mis++;
                $display("FAIL fault_state[%0d]: sticky=%b vec=%0d err=%0d fidx=%0d fdiff=%h, required %b %0d %0d %0d %h",
                         i, m_err_sticky, m_vec_cnt, m_err_cnt, m_first_idx, m_first_diff,
                         mdl_sticky, mdl_vec, mdl_err, CAP ? mdl_fidx : 16'd0, CAP ? mdl_fdiff : 8'd0);
            end
        end
        n_vec++;
        if (m_err_cnt !== 16'd2 || m_first_diff !== (CAP ? 8'h01 : 8'h00) ||
            m_first_idx !== (CAP ? 16'd3 : 16'd0)) begin
            n_mis++;
            $display("FAIL fault_first: err=%0d fidx=%0d fdiff=%h, required 2 %0d %h",
                     m_err_cnt, m_first_idx, m_first_diff, CAP ? 3 : 0, CAP ? 8'h01 : 8'h00);
        end
    endtask

    task automatic test_saturation();
        logic [9:0] e;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(8'h0F, 8'h0F ^ (8'h01 << (i % 8)));
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
            n_vec++;
            if (!s_valid_out || {s_pass, s_fail, s_diff} !== e || s_err_sticky !== 1'b1) begin
                n_mis++;
                $display("FAIL sat_verdict[%0d]: vo=%b pf_diff=%h sticky=%b, required vo=1 %h sticky=1",
                         i, s_valid_out, {s_pass, s_fail, s_diff}, s_err_sticky, e);
            end
        end
        n_vec++;
        if (s_vec_cnt !== 2'd3 || s_err_cnt !== 2'd3 || m_vec_cnt !== 16'd6 || m_err_cnt !== 16'd6) begin
            n_mis++;
            $display("FAIL sat_counts: s_vec=%0d s_err=%0d m_vec=%0d m_err=%0d, required 3 3 6 6",
                     s_vec_cnt, s_err_cnt, m_vec_cnt, m_err_cnt);
        end
    endtask

    task automatic test_clear_collision();
        do_reset();
        drive(8'h11, 8'h10);
        drive(8'h22, 8'h20);
        exp_q.delete();
        n_vec++;
        if (m_err_cnt !== 16'd2) begin
            n_mis++;
            $display("FAIL clear_pre: err=%0d, required 2", m_err_cnt);
        end
        @(negedge clk);
        clear = 1'b1; m_valid = 1'b1; m_dut = 8'hFF; m_ref = 8'h00;
        @(posedge clk);
        #1 clear = 1'b0; m_valid = 1'b0;
        model_reset();
        n_vec++;
        if ({m_valid_out, m_pass, m_fail, m_diff, m_err_sticky, m_vec_cnt, m_err_cnt,
             m_first_idx, m_first_diff} !== '0) begin
            n_mis++;
            $display("FAIL clear_collision: vo=%b vec=%0d err=%0d sticky=%b, required all 0",
                     m_valid_out, m_vec_cnt, m_err_cnt, m_err_sticky);
        end
        // a matching vector afterwards must be index 0 and leave the block passing
        drive(8'h5A, 8'h5A);
        exp_q.delete();
        n_vec++;
        if (!m_pass || m_vec_cnt !== 16'd1 || m_err_sticky !== 1'b0) begin
            n_mis++;
            $display("FAIL clear_after: pass=%b vec=%0d sticky=%b, required 1 1 0",
                     m_pass, m_vec_cnt, m_err_sticky);
        end
    endtask

    task automatic test_gaps_and_reset();
        do_reset();
        for (int v = 0; v < 2; v++) begin
            drive(8'h40 + 8'(v), 8'h40);
            exp_q.delete();
            for (int g = 0; g < 3; g++) begin
                @(negedge clk);
                m_dut = 8'hC3; m_ref = 8'h3C;
                @(posedge clk);
                #1;
                n_vec++;
                if ({m_valid_out, m_pass, m_fail, m_diff} !== '0 ||
                    m_vec_cnt !== mdl_vec || m_err_cnt !== mdl_err) begin
                    n_mis++;
                    $display("FAIL gap[%0d.%0d]: vo=%b diff=%h vec=%0d err=%0d, required 0 00 %0d %0d",
                             v, g, m_valid_out, m_diff, m_vec_cnt, m_err_cnt, mdl_vec, mdl_err);
                end
            end
        end
        @(negedge clk);
        rst = 1'b1; m_valid = 1'b1; m_dut = 8'h01; m_ref = 8'h02;
        @(posedge clk);
        #1 rst = 1'b0; m_valid = 1'b0;
        model_reset();
        n_vec++;
        if ({m_valid_out, m_pass, m_fail, m_diff, m_err_sticky, m_vec_cnt, m_err_cnt,
             m_first_idx, m_first_diff} !== '0) begin
            n_mis++;
            $display("FAIL midreset: vo=%b vec=%0d err=%0d sticky=%b, required all 0",
                     m_valid_out, m_vec_cnt, m_err_cnt, m_err_sticky);
        end
        drive(8'h90, 8'h10);
        exp_q.delete();
        n_vec++;
        if (!m_fail || m_first_idx !== 16'd0 || m_first_diff !== (CAP ? 8'h80 : 8'h00) ||
            m_vec_cnt !== 16'd1) begin
            n_mis++;
            $display("FAIL post_reset_first: fail=%b fidx=%0d fdiff=%h vec=%0d, required 1 0 %h 1",
                     m_fail, m_first_idx, m_first_diff, m_vec_cnt, CAP ? 8'h80 : 8'h00);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_xor_exhaustive();
        test_injected_fault();
        test_saturation();
        test_clear_collision();
        test_gaps_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/lockstep_cmp.md
# lockstep_cmp

Parametrised, clocked self-check comparator for lockstep equivalence testing: two implementations of one function, a device under test and a behavioural golden model, drive `dut_f` and `ref_f`. The block registers a per-vector pass/fail verdict and a bitwise difference vector. It keeps saturating vector and mismatch counters and a sticky error state. It sits between paired model instances in simulation benches and in on-silicon self-test wrappers, replacing per-vector hand-written compare-and-print logic.

## Interface
- `WIDTH`, default 8, width of the compared output word (≥1).
- `CNT_W`, default 16, width of the vector/error counters and the first-mismatch index (≥2).

- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `clear`  input  1  synchronous soft clear of all statistics and state.
- `valid_in`  input  1  `dut_f`/`ref_f` hold a vector to compare this cycle.
- `dut_f`  input  WIDTH  DUT output word.
- `ref_f`  input  WIDTH  reference-model output word.
- `valid_out`  output  1  verdict outputs are valid this cycle (1-cycle pulse).
- `pass`  output  1  vector matched; qualified by `valid_out`.
- `fail`  output  1  vector mismatched; qualified by `valid_out`.
- `diff`  output  WIDTH  `dut_f ^ ref_f` of the reported vector.
- `err_sticky`  output  1  at least one mismatch since the last reset/clear.
- `vec_cnt`  output  CNT_W  vectors compared, saturating.
- `err_cnt`  output  CNT_W  mismatching vectors, saturating.
- `first_idx`  output  CNT_W  `vec_cnt` value at the first mismatch.
- `first_diff`  output  WIDTH  `diff` of the first mismatch.

## Operation
- Compare: `mis = |(dut_f ^ ref_f)`, evaluated only when `valid_in`=1. When `valid_in`=0, inputs are ignored and no state changes.
- State machine, encoded in 2 bits:
  - IDLE: no vector seen. Moves to PASSING on a matching vector and to FAILED on a mismatching one.
  - PASSING: all vectors matched so far. Moves to FAILED on a mismatch.
  - FAILED: absorbing until `rst` or `clear`.
  - `err_sticky` = (state == FAILED).
- Counters:
  - `vec_cnt` increments on every accepted vector.
  - `err_cnt` increments on every mismatch.
  - Both saturate at 2^CNT_W−1 and never wrap. Saturation does not affect the verdict or the state.
- First capture: on the IDLE/PASSING→FAILED transition, `first_idx` ← the pre-increment `vec_cnt` (zero-based vector index) and `first_diff` ← `dut_f ^ ref_f`. Both are frozen afterwards.
- `clear`: same effect as `rst`. It has priority over a same-cycle `valid_in`, and that vector is discarded and not counted.
- `rst` mid-stream: all state is lost. The next accepted vector is index 0.

## Timing
- Latency 1 cycle: a vector sampled at edge N produces `valid_out`, `pass`/`fail` and `diff` high/valid after edge N, for exactly one cycle.
- Back-to-back vectors are accepted every cycle with no stall. The block has no backpressure.
- `pass` and `fail` are mutually exclusive and both 0 when `valid_out`=0. `diff` is 0 when `valid_out`=0.
- Counters, `err_sticky`, `first_idx` and `first_diff` update on the same edge as the verdict.
- Reset/clear values: all outputs 0, state IDLE.

## Configuration
- `LOCKSTEP_CMP_FIRST_CAPTURE_EN`
  - Defined: the `first_idx`/`first_diff` capture registers are built as described in Operation.
  - Undefined: no capture registers are built, and `first_idx` and `first_diff` are tied to 0. All other behaviour is identical.

## Test plan
- Exhaustive 2-input XOR pair, WIDTH=1: apply the vectors (0,0), (1,0), (0,1), (1,1) with both models equal. Required: 4 `pass` pulses, `vec_cnt`=4, `err_cnt`=0, `err_sticky`=0, state PASSING.
- Injected fault, WIDTH=8: vectors 0–2 match; vector 3 has `dut_f`=8'hA5 and `ref_f`=8'hA4. Required:
  - `fail` pulses one cycle after vector 3, with `diff`=8'h01.
  - `err_sticky` is set; `first_idx`=3 and `first_diff`=8'h01 (macro defined).
  - A further mismatch with `diff`=8'h80 leaves `first_diff`=8'h01 and gives `err_cnt`=2.
- Saturation, CNT_W=2: apply 6 mismatching vectors. Required: `vec_cnt`=3 and `err_cnt`=3 (held), with `fail` pulsing all 6 times.
- Clear collision: with `err_cnt`=2, assert `clear` together with a mismatching `valid_in`. Required:
  - The next cycle has `valid_out`=0.
  - All counters are 0, `err_sticky`=0, state IDLE.
- Gaps and reset: send vectors with `valid_in` low for 3 cycles between them. Required: counters unchanged during the gaps and no `valid_out`. Then assert `rst` mid-stream; required: all outputs 0 on the following cycle, and the next mismatch gives `first_idx`=0.
- Macro undefined: repeat the injected-fault scenario. Required: `first_idx`=0 and `first_diff`=0, with all other results unchanged.
